// File: rtl/ntt_pkg.sv
// Shared NTT butterfly constants: operand width and the RNS modulus table
// used by the modular adder, subtractor and multiplier.
package ntt_pkg;

  localparam int WIDTH     = 30;
  localparam int MOD_COUNT = 16;
  localparam int IDX_W     = $clog2(MOD_COUNT);

  typedef logic [WIDTH-1:0] mod_t;
  typedef logic [IDX_W-1:0] mod_idx_t;

  // NTT-friendly primes (k*2^n + 1), all below 2^30; entry 0 is the reset modulus
  localparam mod_t MOD_TABLE [MOD_COUNT] = '{
    30'd998244353,
    30'd754974721,
    30'd469762049,
    30'd167772161,
    30'd1004535809,
    30'd985661441,
    30'd943718401,
    30'd935329793,
    30'd1068564481,
    30'd918552577,
    30'd897581057,
    30'd880803841,
    30'd645922817,
    30'd595591169,
    30'd463470593,
    30'd377487361
  };

  function automatic mod_t mod_lookup(input mod_idx_t idx);
    return MOD_TABLE[idx];
  endfunction

endpackage

// File: rtl/modular_subtractor_mod_rom.sv
// Combinational modulus lookup: 4-bit table index to 30-bit RNS modulus.
// Kept separate so sibling arithmetic blocks can share the same ROM.
module mod_rom
  import ntt_pkg::*;
(
  input  logic [IDX_W-1:0] mod_index,
  output logic [WIDTH-1:0] modulus
);

  always_comb begin
    modulus = mod_lookup(mod_index);
  end

endmodule

// File: rtl/modular_subtractor.sv
// Registered modular subtractor c = (a - b) mod q with a strobe-loaded
// modulus register selecting q from the shared RNS table.
module modular_subtractor
  import ntt_pkg::*;
#(
  parameter int WIDTH     = ntt_pkg::WIDTH,
  parameter int MOD_COUNT = ntt_pkg::MOD_COUNT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mod_sel,
  input  logic [$clog2(MOD_COUNT)-1:0] mod_index,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  output logic [WIDTH-1:0]             c
);

  logic [WIDTH-1:0] table_mod;
  logic [WIDTH-1:0] mod_d, mod_q;
  logic [WIDTH-1:0] c_d, c_q;
  logic [WIDTH:0]   diff;
  logic             borrow;

  mod_rom u_mod_rom (
    .mod_index (mod_index),
    .modulus   (table_mod)
  );

  always_comb begin
    mod_d = mod_q;
    if (mod_sel) begin
      mod_d = table_mod;
    end
  end

  // The extra top bit of the difference is the borrow; on borrow, adding the
  // current modulus and dropping the carry wraps the result back into [0, q).
  always_comb begin
    diff   = {1'b0, a} - {1'b0, b};
    borrow = diff[WIDTH];
    c_d    = diff[WIDTH-1:0];
    if (borrow) begin
      c_d = diff[WIDTH-1:0] + mod_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mod_q <= MOD_TABLE[0];
      c_q   <= '0;
    end else begin
      mod_q <= mod_d;
      c_q   <= c_d;
    end
  end

  assign c = c_q;

endmodule

// File: tb/tb_modular_subtractor.sv
// Directed self-checking bench for modular_subtractor: reset, modulus load,
// borrow/no-borrow paths, boundaries, strobe timing and async reset.
module tb_modular_subtractor;

  localparam logic [29:0] Q0 = 30'd998244353;
  localparam logic [29:0] Q3 = 30'd167772161;
  localparam logic [29:0] Q8 = 30'd1068564481;

  logic        clk;
  logic        rst_n;
  logic        mod_sel;
  logic [3:0]  mod_index;
  logic [29:0] a;
  logic [29:0] b;
  logic [29:0] c;

  int checks;
  int failures;

  modular_subtractor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mod_sel   (mod_sel),
    .mod_index (mod_index),
    .a         (a),
    .b         (b),
    .c         (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a = 30'd5;
    b = 30'd3;
    step();
    step();
    checks++;
    if (c !== 30'd0) begin
      failures++;
      $display("[TB] FAIL reset_c: got %0d expected 0", c);
    end
    checks++;
    if (dut.mod_q !== Q0) begin
      failures++;
      $display("[TB] FAIL reset_mod: got %0d expected %0d", dut.mod_q, Q0);
    end
    rst_n = 1'b1;
    a = 30'd0;
    b = 30'd1;
    step();
    checks++;
    if (c !== Q0 - 30'd1) begin
      failures++;
      $display("[TB] FAIL reset_mod_borrow: got %0d expected %0d", c, Q0 - 30'd1);
    end
  endtask

  task automatic test_mod_load();
    mod_sel   = 1'b1;
    mod_index = 4'd8;
    step();
    mod_sel = 1'b0;
    checks++;
    if (dut.mod_q !== Q8) begin
      failures++;
      $display("[TB] FAIL load_mod: got %0d expected %0d", dut.mod_q, Q8);
    end
    checks++;
    if (c !== Q0 - 30'd1) begin
      failures++;
      $display("[TB] FAIL load_uses_old: got %0d expected %0d", c, Q0 - 30'd1);
    end
  endtask

  task automatic test_no_borrow();
    a = 30'd10; b = 30'd0;
    step();
    checks++;
    if (c !== 30'd10) begin
      failures++;
      $display("[TB] FAIL nb_10_0: got %0d expected 10", c);
    end
    a = 30'd10; b = 30'd8;
    step();
    checks++;
    if (c !== 30'd2) begin
      failures++;
      $display("[TB] FAIL nb_10_8: got %0d expected 2", c);
    end
  endtask

  task automatic test_borrow();
    a = 30'd10; b = 30'd11;
    step();
    checks++;
    if (c !== 30'd1068564480) begin
      failures++;
      $display("[TB] FAIL borrow_10_11: got %0d expected 1068564480", c);
    end
  endtask

  task automatic test_boundaries();
    a = 30'd0; b = 30'd1068564480;
    step();
    checks++;
    if (c !== 30'd1) begin
      failures++;
      $display("[TB] FAIL bnd_0_qm1: got %0d expected 1", c);
    end
    a = 30'd1068564480; b = 30'd0;
    step();
    checks++;
    if (c !== 30'd1068564480) begin
      failures++;
      $display("[TB] FAIL bnd_qm1_0: got %0d expected 1068564480", c);
    end
    a = 30'd1068564480; b = 30'd1068564480;
    step();
    checks++;
    if (c !== 30'd0) begin
      failures++;
      $display("[TB] FAIL bnd_qm1_qm1: got %0d expected 0", c);
    end
    a = 30'd7; b = 30'd7;
    step();
    checks++;
    if (c !== 30'd0) begin
      failures++;
      $display("[TB] FAIL bnd_7_7: got %0d expected 0", c);
    end
  endtask

  task automatic test_strobe_same_edge();
    a = 30'd0; b = 30'd1;
    mod_sel = 1'b1; mod_index = 4'd0;
    step();
    mod_sel = 1'b0;
    checks++;
    if (c !== Q8 - 30'd1) begin
      failures++;
      $display("[TB] FAIL strobe_old_mod: got %0d expected %0d", c, Q8 - 30'd1);
    end
    checks++;
    if (dut.mod_q !== Q0) begin
      failures++;
      $display("[TB] FAIL strobe_mod_reg: got %0d expected %0d", dut.mod_q, Q0);
    end
    step();
    checks++;
    if (c !== Q0 - 30'd1) begin
      failures++;
      $display("[TB] FAIL strobe_new_mod: got %0d expected %0d", c, Q0 - 30'd1);
    end
  endtask

  task automatic test_back_to_back();
    mod_sel = 1'b1; mod_index = 4'd3;
    a = 30'd100; b = 30'd200;
    step();
    checks++;
    if (c !== 30'd998244253) begin
      failures++;
      $display("[TB] FAIL b2b_first: got %0d expected 998244253", c);
    end
    step();
    checks++;
    if (c !== 30'd167772061) begin
      failures++;
      $display("[TB] FAIL b2b_second: got %0d expected 167772061", c);
    end
    a = 30'd500; b = 30'd1;
    step();
    checks++;
    if (c !== 30'd499) begin
      failures++;
      $display("[TB] FAIL b2b_third: got %0d expected 499", c);
    end
    mod_sel = 1'b0;
    a = 30'd0; b = Q3 - 30'd1;
    step();
    checks++;
    if (c !== 30'd1) begin
      failures++;
      $display("[TB] FAIL b2b_fourth: got %0d expected 1", c);
    end
  endtask

  task automatic test_async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (c !== 30'd0) begin
      failures++;
      $display("[TB] FAIL async_clear: got %0d expected 0", c);
    end
    checks++;
    if (dut.mod_q !== Q0) begin
      failures++;
      $display("[TB] FAIL async_mod: got %0d expected %0d", dut.mod_q, Q0);
    end
    #2;
    rst_n = 1'b1;
    a = 30'd5; b = 30'd3;
    step();
    checks++;
    if (c !== 30'd2) begin
      failures++;
      $display("[TB] FAIL post_reset: got %0d expected 2", c);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    mod_sel   = 1'b0;
    mod_index = 4'd0;
    a         = 30'd0;
    b         = 30'd0;
    test_reset();
    test_mod_load();
    test_no_borrow();
    test_borrow();
    test_boundaries();
    test_strobe_same_edge();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
